// File: rtl/channel_rr_merge.sv
// -----------------------------------------------------------------------------
// channel_rr_merge
// Round-robin merge of NUM_INPUTS blocking-channel consumer ports into one
// registered output stream. Each output word carries the index of the source
// that supplied it. When MESSAGE_WORDS > 1 the grant stays on one source until
// a whole message (MESSAGE_WORDS words) has been moved.
//
// Ports
//   clk          in   clock, all state on rising edge
//   reset        in   asynchronous, active-high
//   in_data      in   NUM_INPUTS*WIDTH, word i at [i*WIDTH +: WIDTH]
//   in_valid     in   NUM_INPUTS, upstream channel i holds a word
//   in_is_taken  out  NUM_INPUTS, one-hot pop strobe (combinational)
//   out_data     out  WIDTH, registered word
//   out_source   out  SRC_W, source index of out_data
//   out_valid    out  registered word present
//   out_is_full  in   downstream channel full
// -----------------------------------------------------------------------------
module channel_rr_merge #(
  parameter int WIDTH         = 8,
  parameter int NUM_INPUTS    = 4,
  parameter int MESSAGE_WORDS = 1,
  localparam int SRC_W        = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_is_taken,
  output logic [WIDTH-1:0]            out_data,
  output logic [SRC_W-1:0]            out_source,
  output logic                        out_valid,
  input  logic                        out_is_full
);

  localparam int CNT_W = (MESSAGE_WORDS > 1) ? $clog2(MESSAGE_WORDS + 1) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [SRC_W-1:0]    r_ptr;
  logic [SRC_W-1:0]    r_lock_src;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_can_load;
  logic                w_found;
  logic                w_grant;
  logic [SRC_W-1:0]    w_sel;
  logic [SRC_W:0]      w_idx;
  logic [WIDTH-1:0]    w_data;
  logic [SRC_W-1:0]    w_ptr_next;

  // The output register may be reloaded in the same cycle it hands its word
  // downstream, which keeps a full-rate stream with no bubbles.
  assign w_can_load = !out_valid || !out_is_full;

  // Source selection. IDLE scans ptr, ptr+1, ... with wrap; LOCKED looks only
  // at the source that opened the current message.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    if (r_state == ST_IDLE) begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        // Walking from the far end down lets the nearest candidate win.
        w_idx = {1'b0, r_ptr} + (SRC_W + 1)'(k);
        if (w_idx >= (SRC_W + 1)'(NUM_INPUTS))
          w_idx = w_idx - (SRC_W + 1)'(NUM_INPUTS);
        if (in_valid[w_idx[SRC_W-1:0]]) begin
          w_found = 1'b1;
          w_sel   = w_idx[SRC_W-1:0];
        end
      end
    end else begin
      w_found = in_valid[r_lock_src];
      w_sel   = r_lock_src;
    end
  end

  assign w_grant = w_can_load && w_found;

  // Data mux and one-hot pop strobe; the strobe depends combinationally on
  // out_is_full because there is no skid buffer to absorb a late stall.
  always_comb begin
    w_data      = '0;
    in_is_taken = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_sel == SRC_W'(i)) begin
        w_data = in_data[i*WIDTH +: WIDTH];
        in_is_taken[i] = w_grant;
      end
    end
  end

  assign w_ptr_next = (w_sel == SRC_W'(NUM_INPUTS - 1)) ? '0 : w_sel + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_lock_src <= '0;
      r_cnt      <= '0;
      out_data   <= '0;
      out_source <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (w_grant) begin
        out_data   <= w_data;
        out_source <= w_sel;
        out_valid  <= 1'b1;
        if (r_state == ST_IDLE) begin
          // Only IDLE grants move the round-robin pointer.
          r_ptr <= w_ptr_next;
          if (MESSAGE_WORDS > 1) begin
            r_state    <= ST_LOCKED;
            r_lock_src <= w_sel;
            r_cnt      <= CNT_W'(1);
          end
        end else if (r_cnt == CNT_W'(MESSAGE_WORDS - 1)) begin
          // Last word of the message: release the lock.
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (out_valid && !out_is_full) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
